// File: rtl/uart_boot_if.sv
// Loader-side bundle: received UART bytes in, RAM write port and boot status out.
// master = boot loader, slave = the UART receiver / RAM controller / core side.
interface uart_boot_if;
  logic        rx_data_ready;
  logic [7:0]  rx_data;
  logic [31:0] ram_address;
  logic [31:0] ram_write;
  logic        ram_write_enable;
  logic        core_hold;
  logic        boot_done;
  logic        boot_error;

  modport master (
    input  rx_data_ready,
    input  rx_data,
    output ram_address,
    output ram_write,
    output ram_write_enable,
    output core_hold,
    output boot_done,
    output boot_error
  );

  modport slave (
    output rx_data_ready,
    output rx_data,
    input  ram_address,
    input  ram_write,
    input  ram_write_enable,
    input  core_hold,
    input  boot_done,
    input  boot_error
  );
endinterface

// File: rtl/uart_boot_loader.sv
// Serial boot loader: SYNC, 32-bit LEN, LEN little-endian words written sequentially to RAM.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte over LEN and data bytes.
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input logic         clk,
  input logic         rst_n,
  uart_boot_if.master bus
);

  typedef enum logic [2:0] {
    StWaitSync,
    StLen,
    StData,
    StLast,
    StCsum,
    StDone,
    StError
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] len_q, len_d;
  logic [31:0] index_q, index_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] shift_full;

  // Length and data words share one LSB-first shift register.
  assign shift_full = {bus.rx_data, shift_q[31:8]};

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == StWaitSync && bus.rx_data_ready && bus.rx_data == SYNC_BYTE) begin
      csum_d = 8'h00;
    end else if ((state_q == StLen || state_q == StData) && bus.rx_data_ready) begin
      csum_d = csum_q ^ bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    len_d      = len_q;
    index_d    = index_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;

    unique case (state_q)
      StWaitSync: begin
        if (bus.rx_data_ready && bus.rx_data == SYNC_BYTE) begin
          state_d    = StLen;
          byte_cnt_d = 2'd0;
        end
      end
      StLen: begin
        if (bus.rx_data_ready) begin
          shift_d    = shift_full;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            len_d   = shift_full;
            index_d = 32'd0;
            if (shift_full > MAX_WORDS) begin
              state_d = StError;
              err_d   = 1'b1;
            end else if (shift_full == 32'd0) begin
`ifdef BOOT_CHECKSUM_EN
              state_d = StCsum;
`else
              state_d = StDone;
              done_d  = 1'b1;
              hold_d  = 1'b0;
`endif
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (bus.rx_data_ready) begin
          shift_d    = shift_full;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = shift_full;
            addr_d  = BASE_ADDR + (index_q << 2);
            index_d = index_q + 32'd1;
            if (index_q + 32'd1 == len_q) begin
              state_d = StLast;
            end
          end
        end
      end
      // One cycle after the final write strobe.
      StLast: begin
`ifdef BOOT_CHECKSUM_EN
        state_d = StCsum;
`else
        state_d = StDone;
        done_d  = 1'b1;
        hold_d  = 1'b0;
`endif
      end
      StCsum: begin
`ifdef BOOT_CHECKSUM_EN
        if (bus.rx_data_ready) begin
          if (bus.rx_data == csum_q) begin
            state_d = StDone;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = StError;
            err_d   = 1'b1;
          end
        end
`else
        state_d = StError;
        err_d   = 1'b1;
`endif
      end
      StDone:  ;
      StError: ;
      default: begin
        state_d = StError;
        err_d   = 1'b1;
        done_d  = 1'b0;
        hold_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StWaitSync;
      byte_cnt_q <= 2'd0;
      shift_q    <= 32'd0;
      len_q      <= 32'd0;
      index_q    <= 32'd0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      index_q    <= index_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.ram_address      = addr_q;
  assign bus.ram_write        = wdata_q;
  assign bus.ram_write_enable = we_q;
  assign bus.core_hold        = hold_q;
  assign bus.boot_done        = done_q;
  assign bus.boot_error       = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed frames plus random frames checked against a
// stream-parsing reference model. Follows BOOT_CHECKSUM_EN the same way as the design.
module tb_uart_boot_loader;
  localparam logic [31:0] Base = 32'h0000_0000;
  localparam int unsigned MaxW = 4096;

  typedef logic [7:0]  bq_t[$];
  typedef logic [63:0] wq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  wq_t  obs_q;

  always #5 clk = ~clk;

  uart_boot_if bus ();

  uart_boot_loader #(
    .BASE_ADDR(Base),
    .MAX_WORDS(MaxW),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Record every write strobe cycle; a stretched pulse shows up as an extra entry.
  always @(negedge clk) begin
    if (rst_n && bus.ram_write_enable) obs_q.push_back({bus.ram_address, bus.ram_write});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.rx_data_ready = 1'b1;
    bus.rx_data       = b;
    @(negedge clk);
    bus.rx_data_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n             = 1'b0;
    bus.rx_data_ready = 1'b0;
    @(negedge clk);
    obs_q.delete();
    check("rst-hold", bus.core_hold, 1);
    check("rst-done", bus.boot_done, 0);
    check("rst-err", bus.boot_error, 0);
    check("rst-we", bus.ram_write_enable, 0);
    check("rst-addr", bus.ram_address, Base);
    check("rst-data", bus.ram_write, 0);
    rst_n = 1'b1;
  endtask

  // Builds SYNC + LEN + data (+ checksum, optionally corrupted).
  function automatic bq_t frame(input logic [31:0] len, input bq_t data, input bit bad_csum);
    bq_t  s;
    logic [7:0] c;
    s = '{8'hA5, len[7:0], len[15:8], len[23:16], len[31:24]};
    foreach (data[j]) s.push_back(data[j]);
`ifdef BOOT_CHECKSUM_EN
    c = 8'h00;
    for (int j = 1; j < s.size(); j++) c ^= s[j];
    if (bad_csum) c ^= 8'($urandom_range(1, 255));
    s.push_back(c);
`else
    c = {7'd0, bad_csum};
    if (c != 8'h00) c = 8'h00;
`endif
    return s;
  endfunction

  // Reference: parse a whole byte stream into expected writes and final status.
  task automatic model(input bq_t s, output wq_t w, output logic done, output logic err);
    int         i;
    int         st;
    logic [31:0] len;
    logic [7:0]  x;
    w = {};
    done = 1'b0;
    err = 1'b0;
    i = 0;
    while (i < s.size() && s[i] != 8'hA5) i++;
    if (i + 4 >= s.size()) return;
    st  = i + 1;
    len = {s[i+4], s[i+3], s[i+2], s[i+1]};
    i += 5;
    if (len > MaxW) begin
      err = 1'b1;
      return;
    end
    if (i + 4 * int'(len) > s.size()) return;
    for (int k = 0; k < int'(len); k++) begin
      w.push_back({Base + 32'(4 * k), s[i+4*k+3], s[i+4*k+2], s[i+4*k+1], s[i+4*k]});
    end
    i += 4 * int'(len);
`ifdef BOOT_CHECKSUM_EN
    x = 8'h00;
    for (int j = st; j < i; j++) x ^= s[j];
    if (i >= s.size()) return;
    if (s[i] == x) done = 1'b1;
    else err = 1'b1;
`else
    x = 8'(st);
    done = 1'b1;
`endif
  endtask

  task automatic run_stream(input string tag, input bq_t s);
    wq_t  exp_w;
    logic ed;
    logic ee;
    do_reset();
    foreach (s[j]) send_byte(s[j], $urandom_range(0, 2));
    repeat (3) @(negedge clk);
    model(s, exp_w, ed, ee);
    check({tag, "-nwr"}, 64'(obs_q.size()), 64'(exp_w.size()));
    for (int k = 0; k < exp_w.size() && k < obs_q.size(); k++) begin
      check($sformatf("%s-wr%0d", tag, k), obs_q[k], exp_w[k]);
    end
    check({tag, "-done"}, bus.boot_done, ed);
    check({tag, "-err"}, bus.boot_error, ee);
    check({tag, "-hold"}, bus.core_hold, !ed);
  endtask

  initial begin
    bq_t s;
    bq_t d;
    bus.rx_data_ready = 1'b0;
    bus.rx_data       = 8'h00;

    // Test 1 with exact write timing.
    do_reset();
    d = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    s = frame(2, d, 1'b0);
    for (int j = 0; j < s.size(); j++) begin
      send_byte(s[j], 0);
      if (j == 8) begin
        check("t1-we0", bus.ram_write_enable, 1);
        check("t1-addr0", bus.ram_address, 32'h0);
        check("t1-data0", bus.ram_write, 32'h1234_5678);
      end
      if (j == 12) begin
        check("t1-we1", bus.ram_write_enable, 1);
        check("t1-addr1", bus.ram_address, 32'h4);
        check("t1-data1", bus.ram_write, 32'hDEAD_BEEF);
        check("t1-early-done", bus.boot_done, 0);
`ifndef BOOT_CHECKSUM_EN
        @(negedge clk);
        check("t1-done-lat", bus.boot_done, 1);
        check("t1-addr-hold", bus.ram_address, 32'h4);
`endif
      end
    end
    repeat (2) @(negedge clk);
    check("t1-nwr", 64'(obs_q.size()), 2);
    check("t1-done", bus.boot_done, 1);
    check("t1-hold", bus.core_hold, 0);

    // Test 2: leading junk ignored.
    s = {8'h00, 8'hFF, 8'h3C};
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    s = {s, frame(1, d, 1'b0)};
    run_stream("t2", s);

    // Test 3: oversize length, trailing bytes produce no writes.
    run_stream("t3", '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55});

    // Test 4: zero length, done one cycle after the last length byte.
    do_reset();
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1);
    send_byte(8'h00, 0);
`ifdef BOOT_CHECKSUM_EN
    check("t4-pre-csum", bus.boot_done, 0);
    send_byte(8'h00, 0);
`endif
    check("t4-done", bus.boot_done, 1);
    check("t4-hold", bus.core_hold, 0);
    check("t4-nwr", 64'(obs_q.size()), 0);

`ifdef BOOT_CHECKSUM_EN
    // Test 5: good and bad checksum.
    run_stream("t5a", '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
    run_stream("t5b", '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06});
`endif

    // Test 6: reset mid-load, then resend.
    do_reset();
    d = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    s = frame(2, d, 1'b0);
    for (int j = 0; j < 7; j++) send_byte(s[j], 1);
    run_stream("t6", s);

    // Random frames with junk, trailing bytes, oversize lengths and bad checksums.
    for (int it = 0; it < 24; it++) begin
      bq_t         rs;
      bq_t         rd;
      logic [31:0] len;
      logic [7:0]  b;
      int          nj;
      rs = {};
      rd = {};
      nj = $urandom_range(0, 3);
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        rs.push_back(b);
      end
      if ($urandom_range(0, 5) == 0) len = MaxW + 1 + $urandom_range(0, 3);
      else len = $urandom_range(0, 6);
      if (len <= MaxW) begin
        for (int j = 0; j < 4 * int'(len); j++) rd.push_back(8'($urandom_range(0, 255)));
        rs = {rs, frame(len, rd, $urandom_range(0, 2) == 0)};
      end else begin
        rs = {rs, 8'hA5, len[7:0], len[15:8], len[23:16], len[31:24]};
      end
      nj = $urandom_range(0, 3);
      for (int j = 0; j < nj; j++) rs.push_back(8'($urandom_range(0, 255)));
      run_stream($sformatf("rnd%0d", it), rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
